// File: rtl/spi_adc_pkg.sv
// -----------------------------------------------------------------------------
// spi_adc_pkg
// Shared definitions for the SPI ADC read-out controller:
//   - state_t     : frame sequencer states (IDLE, SETUP, HIGH, LOW, DONE)
//   - DEF_DATA_W  : default conversion word width
//   - DEF_CLK_DIV : default clk cycles per SCLK half-period
//   - cnt_w()     : counter width helper that never returns zero
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package spi_adc_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_CLK_DIV = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Bits needed to hold values 0..n-1; at least 1 so a divide-by-1
    // counter still has a legal declaration.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_adc_if.sv
// -----------------------------------------------------------------------------
// spi_adc_if
// Bundles the ADC-side SPI pins and the parallel word output of spi_adc.
//   nDRDY   : ADC data-ready, active-low, asynchronous to clk
//   SDIN    : ADC serial data (MISO)
//   SCLK    : serial clock, idles low
//   nCS     : ADC chip select, active-low
//   SDOUT   : MOSI (only when SPI_ADC_SDOUT_EN is defined)
//   drdy    : one-cycle strobe, dataout holds a new word
//   dataout : last captured conversion word
// Modports: master = the controller, slave = the ADC / consumer side.
// Optional feature macro: SPI_ADC_SDOUT_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface spi_adc_if
    import spi_adc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    logic              nDRDY;
    logic              SDIN;
    logic              SCLK;
    logic              nCS;
    logic              drdy;
    logic [DATA_W-1:0] dataout;
`ifdef SPI_ADC_SDOUT_EN
    logic              SDOUT;
`endif

`ifdef SPI_ADC_SDOUT_EN
    modport master (
        input  nDRDY, SDIN,
        output SCLK, nCS, drdy, dataout, SDOUT
    );

    modport slave (
        output nDRDY, SDIN,
        input  SCLK, nCS, drdy, dataout, SDOUT
    );
`else
    modport master (
        input  nDRDY, SDIN,
        output SCLK, nCS, drdy, dataout
    );

    modport slave (
        output nDRDY, SDIN,
        input  SCLK, nCS, drdy, dataout
    );
`endif

endinterface

// File: rtl/spi_adc_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_adc_sync_edge
// Two-flop synchronizer for the asynchronous active-low nDRDY strobe,
// followed by a falling-edge detector.
//   clk     : system clock
//   res     : synchronous reset, active-low
//   async_n : raw asynchronous active-low input
//   fall    : high for one cycle after the synchronized input goes 1 -> 0
// All flops reset to 1 so releasing reset while the input is already low
// never produces a spurious edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module spi_adc_sync_edge
    import spi_adc_pkg::*;
(
    input  logic clk,
    input  logic res,
    input  logic async_n,
    output logic fall
);

    logic meta;
    logic synced;
    logic prev;

    always_ff @(posedge clk) begin
        if (!res) begin
            meta   <= 1'b1;
            synced <= 1'b1;
            prev   <= 1'b1;
        end else begin
            meta   <= async_n;
            synced <= meta;
            prev   <= synced;
        end
    end

    assign fall = prev & ~synced;

endmodule

// File: rtl/spi_adc.sv
// -----------------------------------------------------------------------------
// spi_adc
// Serial read-out controller for an external SPI ADC. After each falling
// edge of nDRDY it runs one read frame: nCS low, a SETUP half-period, then
// DATA_W SCLK periods sampling SDIN MSB-first on each SCLK rising edge.
// The word appears on dataout together with a one-cycle drdy strobe on the
// same edge that releases nCS.
//
// Ports:
//   clk : system clock (rising edge)
//   res : synchronous reset, active-low
//   bus : spi_adc_if.master (nDRDY, SDIN, SCLK, nCS, drdy, dataout[, SDOUT])
//
// Parameters:
//   DATA_W   : bits per conversion word
//   CLK_DIV  : clk cycles per SCLK half-period (minimum 1)
//   CMD_WORD : word shifted out on SDOUT (only with SPI_ADC_SDOUT_EN)
//
// Optional feature macro: SPI_ADC_SDOUT_EN adds the SDOUT transmit path.
//
// nCS low time is CLK_DIV + 2*DATA_W*CLK_DIV cycles. nDRDY edges detected
// while a frame is in progress are dropped.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module spi_adc
    import spi_adc_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CLK_DIV = DEF_CLK_DIV
`ifdef SPI_ADC_SDOUT_EN
    ,
    parameter logic [DATA_W-1:0] CMD_WORD = '0
`endif
)
(
    input  logic       clk,
    input  logic       res,
    spi_adc_if.master  bus
);

    localparam int DIV_W = cnt_w(CLK_DIV);
    localparam int BIT_W = cnt_w(DATA_W + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    state_t            state;
    logic [DIV_W-1:0]  divcnt;
    logic [BIT_W-1:0]  bitcnt;
    logic [DATA_W-1:0] shreg;

    logic              ncs_r;
    logic              sclk_r;
    logic              drdy_r;
    logic [DATA_W-1:0] dataout_r;

    logic              fall;
    logic              div_last;
    logic              shift_en;

`ifdef SPI_ADC_SDOUT_EN
    logic [DATA_W-1:0] txreg;
    logic              sdout_r;
    logic              tx_load;
    logic              tx_shift;
`endif

    // nDRDY synchronizer and edge detect
    spi_adc_sync_edge u_sync (
        .clk     (clk),
        .res     (res),
        .async_n (bus.nDRDY),
        .fall    (fall)
    );

    assign div_last = (divcnt == DIV_LAST);

    // Sample SDIN on every transition into HIGH: leaving SETUP, or leaving
    // LOW when more bits remain.
    assign shift_en = div_last &&
                      ((state == SETUP) ||
                       ((state == LOW) && (bitcnt != BIT_LAST)));

    // Frame sequencer; all pin outputs are registered here.
    always_ff @(posedge clk) begin
        if (!res) begin
            state     <= IDLE;
            divcnt    <= '0;
            bitcnt    <= '0;
            ncs_r     <= 1'b1;
            sclk_r    <= 1'b0;
            drdy_r    <= 1'b0;
            dataout_r <= '0;
`ifdef SPI_ADC_SDOUT_EN
            sdout_r   <= 1'b0;
`endif
        end else begin
            drdy_r <= 1'b0;

            case (state)
                IDLE: begin
                    ncs_r  <= 1'b1;
                    sclk_r <= 1'b0;
                    if (fall) begin
                        state  <= SETUP;
                        ncs_r  <= 1'b0;
                        bitcnt <= '0;
                        divcnt <= '0;
`ifdef SPI_ADC_SDOUT_EN
                        sdout_r <= CMD_WORD[DATA_W-1];
`endif
                    end
                end

                SETUP: begin
                    if (div_last) begin
                        divcnt <= '0;
                        sclk_r <= 1'b1;
                        state  <= HIGH;
                    end else begin
                        divcnt <= divcnt + 1'b1;
                    end
                end

                HIGH: begin
                    if (div_last) begin
                        divcnt <= '0;
                        sclk_r <= 1'b0;
                        state  <= LOW;
`ifdef SPI_ADC_SDOUT_EN
                        // Next transmit bit, matching the txreg shift below.
                        sdout_r <= txreg[DATA_W-2];
`endif
                    end else begin
                        divcnt <= divcnt + 1'b1;
                    end
                end

                LOW: begin
                    if (div_last) begin
                        divcnt <= '0;
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == BIT_LAST) begin
                            // Last bit already shifted in: close the frame.
                            state     <= DONE;
                            ncs_r     <= 1'b1;
                            drdy_r    <= 1'b1;
                            dataout_r <= shreg;
`ifdef SPI_ADC_SDOUT_EN
                            sdout_r   <= 1'b0;
`endif
                        end else begin
                            sclk_r <= 1'b1;
                            state  <= HIGH;
                        end
                    end else begin
                        divcnt <= divcnt + 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state  <= IDLE;
                    ncs_r  <= 1'b1;
                    sclk_r <= 1'b0;
                end
            endcase
        end
    end

    // Receive shift register; contents are irrelevant until DONE copies
    // them, so it carries no reset.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            shreg <= {shreg[DATA_W-2:0], bus.SDIN};
        end
    end

`ifdef SPI_ADC_SDOUT_EN
    assign tx_load  = (state == IDLE) && fall;
    assign tx_shift = (state == HIGH) && div_last;

    // Transmit shift register: loaded as the frame opens, advanced on
    // each SCLK falling edge.
    always_ff @(posedge clk) begin
        if (tx_load) begin
            txreg <= CMD_WORD;
        end else if (tx_shift) begin
            txreg <= {txreg[DATA_W-2:0], 1'b0};
        end
    end

    assign bus.SDOUT = sdout_r;
`endif

    assign bus.nCS     = ncs_r;
    assign bus.SCLK    = sclk_r;
    assign bus.drdy    = drdy_r;
    assign bus.dataout = dataout_r;

endmodule

// File: tb/tb_spi_adc.sv
`timescale 1ns/1ps

module tb_spi_adc;

    localparam int DATA_W    = 16;
    localparam int CLK_DIV   = 2;
    localparam int FRAME_LEN = CLK_DIV + 2 * DATA_W * CLK_DIV;  // 66

    logic clk;
    logic res;

    spi_adc_if #(.DATA_W(DATA_W)) bus ();

    spi_adc #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // ---------------- counters and scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    logic [DATA_W-1:0] exp_q[$];

    // Written only by the monitor below
    int              drdy_cnt     = 0;
    int              drdy_bad     = 0;
    int              frames_ended = 0;
    int              cur_len      = 0;
    int              cur_edges    = 0;
    int              last_len     = 0;
    int              last_edges   = 0;
    logic [DATA_W-1:0] got_words[64];
    logic            prev_ncs     = 1'b1;
    logic            prev_sclk    = 1'b0;
    int              idx          = DATA_W - 1;
    logic            sdin_drv     = 1'b0;

    // Written only by the test process
    logic [DATA_W-1:0] tx_word = '0;

    assign bus.SDIN = sdin_drv;

    // Monitor + ADC model, evaluated on the falling clk edge
    always @(negedge clk) begin
        if (bus.drdy === 1'b1) begin
            if (!(prev_ncs === 1'b0 && bus.nCS === 1'b1)) drdy_bad++;
            if (drdy_cnt < 64) got_words[drdy_cnt] = bus.dataout;
            drdy_cnt++;
        end
        if (prev_ncs === 1'b1 && bus.nCS === 1'b0) begin
            cur_len   = 0;
            cur_edges = 0;
        end
        if (bus.nCS === 1'b0) begin
            cur_len++;
            if (prev_sclk === 1'b0 && bus.SCLK === 1'b1) cur_edges++;
        end
        if (prev_ncs === 1'b0 && bus.nCS === 1'b1) begin
            last_len   = cur_len;
            last_edges = cur_edges;
            frames_ended++;
        end
        // ADC: present MSB when selected, advance after each SCLK fall
        if (bus.nCS !== 1'b0) idx = DATA_W - 1;
        else if (prev_sclk === 1'b1 && bus.SCLK === 1'b0) idx--;
        sdin_drv  = (idx >= 0) ? tx_word[idx] : 1'b0;
        prev_ncs  = bus.nCS;
        prev_sclk = bus.SCLK;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        string             tag;
        logic [DATA_W-1:0] word;      // ADC output word
        int                low_cyc;   // nDRDY low pulse length
        int                repulse;   // cycle into frame for a 2nd pulse (0 = none)
        int                gap;       // idle cycles after the frame
        logic [DATA_W-1:0] exp_word;
        int                exp_len;
        int                exp_edges;
    } vec_t;

    vec_t vecs[7];

    // Drive one nDRDY pulse, wait for the frame, compare it.
    task automatic run_frame(input vec_t v);
        int  f0;
        int  d0;
        bit  done;
        logic [DATA_W-1:0] exp_w;
        tx_word = v.word;
        exp_q.push_back(v.exp_word);
        f0 = frames_ended;
        d0 = drdy_cnt;
        bus.nDRDY = 1'b0;
        repeat (v.low_cyc) step();
        bus.nDRDY = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            step();
            if (v.repulse > 0 && i == v.repulse)     bus.nDRDY = 1'b0;
            if (v.repulse > 0 && i == v.repulse + 2) bus.nDRDY = 1'b1;
            if (frames_ended != f0) done = 1'b1;
        end
        bus.nDRDY = 1'b1;
        check({v.tag, "_frame_seen"}, 32'(done), 32'd1);
        check({v.tag, "_ncs_len"}, 32'(last_len), 32'(v.exp_len));
        check({v.tag, "_sclk_edges"}, 32'(last_edges), 32'(v.exp_edges));
        check({v.tag, "_drdy_count"}, 32'(drdy_cnt - d0), 32'd1);
        exp_w = exp_q.pop_front();
        if (drdy_cnt > d0) check({v.tag, "_dataout"}, 32'(got_words[d0]), 32'(exp_w));
        else               check({v.tag, "_dataout_missing"}, 32'd0, 32'd1);
        repeat (v.gap) step();
        check({v.tag, "_no_extra_frame"}, 32'(frames_ended - f0), 32'd1);
        check({v.tag, "_drdy_aligned"}, 32'(drdy_bad), 32'd0);
    endtask

    // Watchdog
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // ---------------- test ----------------
    initial begin
        vecs[0] = '{"ones",    16'hFFFF, 2,  0,  10,   16'hFFFF, FRAME_LEN, DATA_W};
        vecs[1] = '{"a5c3",    16'hA5C3, 2,  0,  10,   16'hA5C3, FRAME_LEN, DATA_W};
        vecs[2] = '{"zeros",   16'h0000, 2,  0,  1000, 16'h0000, FRAME_LEN, DATA_W};
        vecs[3] = '{"x1234",   16'h1234, 5,  0,  10,   16'h1234, FRAME_LEN, DATA_W};
        vecs[4] = '{"x8001",   16'h8001, 2,  0,  4,    16'h8001, FRAME_LEN, DATA_W};
        vecs[5] = '{"x7ffe",   16'h7FFE, 3,  0,  10,   16'h7FFE, FRAME_LEN, DATA_W};
        vecs[6] = '{"repulse", 16'h3C3C, 2,  20, 30,   16'h3C3C, FRAME_LEN, DATA_W};

        // Reset, one cycle, nDRDY idle
        res       = 1'b0;
        bus.nDRDY = 1'b1;
        step();
        check("reset_ncs",     32'(bus.nCS),     32'd1);
        check("reset_sclk",    32'(bus.SCLK),    32'd0);
        check("reset_drdy",    32'(bus.drdy),    32'd0);
        check("reset_dataout", 32'(bus.dataout), 32'h0000);
        res = 1'b1;
        repeat (5) step();

        for (int k = 0; k < 7; k++) run_frame(vecs[k]);

        // Edge-to-nCS latency: nCS must fall on the 3rd sampling edge
        begin
            int  edges;
            int  f0;
            int  d0;
            bit  done;
            logic [DATA_W-1:0] exp_w;
            tx_word = 16'hC001;
            exp_q.push_back(16'hC001);
            f0 = frames_ended;
            d0 = drdy_cnt;
            edges = 0;
            bus.nDRDY = 1'b0;
            for (int i = 0; i < 10; i++) begin
                step();
                edges++;
                if (edges == 2) bus.nDRDY = 1'b1;
                if (bus.nCS === 1'b0) break;
            end
            bus.nDRDY = 1'b1;
            check("latency_edges", 32'(edges), 32'd3);
            done = 1'b0;
            for (int i = 0; i < 300 && !done; i++) begin
                step();
                if (frames_ended != f0) done = 1'b1;
            end
            check("latency_frame_seen", 32'(done), 32'd1);
            exp_w = exp_q.pop_front();
            if (drdy_cnt > d0) check("latency_dataout", 32'(got_words[d0]), 32'(exp_w));
            else               check("latency_dataout_missing", 32'd0, 32'd1);
            repeat (10) step();
        end

        // Reset asserted mid-frame at bit 8
        begin
            int d0;
            bit hit;
            tx_word = 16'hFFFF;
            d0 = drdy_cnt;
            bus.nDRDY = 1'b0;
            repeat (2) step();
            bus.nDRDY = 1'b1;
            hit = 1'b0;
            for (int i = 0; i < 200 && !hit; i++) begin
                step();
                if (bus.nCS === 1'b0 && cur_edges >= 8) hit = 1'b1;
            end
            check("abort_reached_bit8", 32'(hit), 32'd1);
            res = 1'b0;
            step();
            check("abort_ncs",     32'(bus.nCS),     32'd1);
            check("abort_sclk",    32'(bus.SCLK),    32'd0);
            check("abort_drdy",    32'(bus.drdy),    32'd0);
            check("abort_dataout", 32'(bus.dataout), 32'h0000);
            res = 1'b1;
            repeat (150) step();
            check("abort_no_drdy",   32'(drdy_cnt - d0), 32'd0);
            check("abort_ncs_quiet", 32'(bus.nCS),       32'd1);
        end

        // Normal frame after the aborted one
        begin
            vec_t v;
            v = '{"post_abort", 16'h5AA5, 2, 0, 10, 16'h5AA5, FRAME_LEN, DATA_W};
            run_frame(v);
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
